mem_port_arbiter: RTL and testbench

// - Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).
// - Sequences each access as a req/ack transaction with variable latency.
// - Returns read data to the requesting stage and drives stall requests that the hazard unit ORs into StallF / StallM.
// - Sits between the pipeline datapath and the memory wrapper.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/arb_timeout_ctr.sv | 28 ++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline package: memory port widths and arbiter state encoding.
package cpu_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_I_BUSY = 2'd1,
        ARB_D_BUSY = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Loadable down-counter with an expire flag for bus-master watchdogs.
module arb_timeout_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A zero load never reaches one, so it disables expiry.
    assign expired = en && (cnt == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store, with
// fetch anti-starvation, fetch squash and a sticky bus timeout.
module mem_port_arbiter #(
    parameter int ADDR_W     = cpu_pkg::ADDR_W,
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_cancel,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                bus_err
);
    import cpu_pkg::*;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    arb_state_t    state;
    arb_state_t    state_n;
    logic [SW-1:0] starve_cnt;
    logic          starved;
    logic          cancel_q;
    logic          grant_i;
    logic          grant_d;
    logic          busy;
    logic          expired;
    logic          finish;

    assign busy      = (state != ARB_IDLE);
    assign finish    = busy && (mem_ack || expired);
    assign starved   = (starve_cnt >= SW'(STARVE_MAX));
    assign stall_if  = i_req & ~i_ready;
    assign stall_mem = d_req & ~d_ready;

    arb_timeout_ctr #(
        .W(CW)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .load    (grant_i | grant_d),
        .load_val(CW'(TIMEOUT)),
        .en      (busy),
        .expired (expired)
    );

    always_comb begin
        state_n = state;
        grant_i = 1'b0;
        grant_d = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                // The ready cycle still sees the old req; never regrant it.
                if (!i_ready && !d_ready) begin
                    if (d_req && !starved)
                        grant_d = 1'b1;
                    else if (i_req && !i_cancel)
                        grant_i = 1'b1;
                    else if (d_req)
                        grant_d = 1'b1;
                end
                if (grant_d)
                    state_n = ARB_D_BUSY;
                else if (grant_i)
                    state_n = ARB_I_BUSY;
            end
            ARB_I_BUSY, ARB_D_BUSY: begin
                if (mem_ack || expired)
                    state_n = ARB_IDLE;
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ARB_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (grant_i) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wstrb <= d_we ? d_wstrb : '0;
        end else if (finish) begin
            mem_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_ready  <= 1'b0;
            d_ready  <= 1'b0;
            bus_err  <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            if (finish) begin
                cancel_q <= 1'b0;
                if (!mem_ack)
                    bus_err <= 1'b1;
                if (state == ARB_I_BUSY) begin
                    i_rdata <= mem_ack ? mem_rdata : '0;
                    i_ready <= ~(cancel_q | i_cancel);
                end else begin
                    d_rdata <= mem_ack ? mem_rdata : '0;
                    d_ready <= 1'b1;
                end
            end else if (state == ARB_I_BUSY && i_cancel) begin
                cancel_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (grant_i)
            starve_cnt <= '0;
        else if (grant_d && i_req && !starved)
            starve_cnt <= starve_cnt + 1'b1;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a memory
// responder and a word-array reference of memory contents.
module tb_mem_port_arbiter;

    localparam int TMO  = 8;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_cancel, i_ready;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_ready;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        stall_if, stall_mem, bus_err;

    int n_assert = 0;
    int n_fail   = 0;
    int ack_lat  = 0;
    logic [31:0] dev_mem   [128];
    logic [31:0] model_mem [128];

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_store(input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] ws);
        for (int b = 0; b < 4; b++)
            if (ws[b]) model_mem[a[8:2]][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic wait_i(input int maxc, output int cyc);
        cyc = -1;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (i_ready) begin cyc = k; break; end
        end
    endtask

    task automatic wait_d(input int maxc, output int cyc);
        cyc = -1;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (d_ready) begin cyc = k; break; end
        end
    endtask

    // Memory device: acks after ack_lat mem_req cycles (-1 never, -2 random)
    initial begin
        int busy_cyc;
        int cur_lat;
        busy_cyc = 0;
        cur_lat = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = '0;
            if (!mem_req) begin
                busy_cyc = 0;
            end else begin
                if (busy_cyc == 0)
                    cur_lat = (ack_lat == -2) ? int'($urandom_range(0, 3)) : ack_lat;
                if (busy_cyc == cur_lat) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b])
                                dev_mem[mem_addr[8:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                    end else begin
                        mem_rdata = dev_mem[mem_addr[8:2]];
                    end
                end
                busy_cyc++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc, n_d, d_run, i_wait, d_wait;
        logic got_i, prev;

        reset = 1'b1;
        i_req = 0; i_addr = '0; i_cancel = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        for (int i = 0; i < 128; i++) begin
            dev_mem[i]   = 32'hA500_0000 + i * 32'h0001_0203;
            model_mem[i] = 32'hA500_0000 + i * 32'h0001_0203;
        end
        dev_mem[4]   = 32'h0010_0093;
        model_mem[4] = 32'h0010_0093;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_bus", {mem_we, mem_addr, mem_wstrb}, '0);
        chk("rst_ready", {i_ready, d_ready}, 2'b00);
        chk("rst_rdata", {i_rdata, d_rdata}, '0);
        chk("rst_bus_err", bus_err, 1'b0);
        reset = 1'b0;

        // Single fetch, ack in first mem_req cycle
        ack_lat = 0;
        @(negedge clk);
        i_req = 1; i_addr = 32'h10;
        @(negedge clk);
        chk("f_mem_req", mem_req, 1'b1);
        chk("f_mem_addr", mem_addr, 32'h10);
        chk("f_mem_rd", {mem_we, mem_wstrb}, 5'h0);
        chk("f_stall", stall_if, 1'b1);
        @(negedge clk);
        chk("f_ready", i_ready, 1'b1);
        chk("f_rdata", i_rdata, 32'h0010_0093);
        chk("f_req_drop", mem_req, 1'b0);
        chk("f_stall_off", stall_if, 1'b0);
        i_req = 0;
        @(negedge clk);
        chk("f_ready_pulse", i_ready, 1'b0);

        // Simultaneous fetch and store: data first
        @(negedge clk);
        i_req = 1; i_addr = 32'h14;
        d_req = 1; d_we = 1; d_addr = 32'h100;
        d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        @(negedge clk);
        chk("sim_d_first", {mem_req, mem_we}, 2'b11);
        chk("sim_d_addr", mem_addr, 32'h100);
        chk("sim_d_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("sim_d_wstrb", mem_wstrb, 4'hF);
        chk("sim_stall_mem", stall_mem, 1'b1);
        chk("sim_stall_if1", stall_if, 1'b1);
        @(negedge clk);
        chk("sim_d_ready", d_ready, 1'b1);
        chk("sim_stall_if2", stall_if, 1'b1);
        d_req = 0;
        model_store(32'h100, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        chk("sim_gap", mem_req, 1'b0);
        chk("sim_stall_if3", stall_if, 1'b1);
        @(negedge clk);
        chk("sim_i_next", {mem_req, mem_we}, 2'b10);
        chk("sim_i_addr", mem_addr, 32'h14);
        chk("sim_stall_if4", stall_if, 1'b1);
        @(negedge clk);
        chk("sim_i_ready", i_ready, 1'b1);
        chk("sim_i_rdata", i_rdata, model_mem[5]);
        i_req = 0;

        // Read the store back
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'h100;
        wait_d(10, cyc);
        chk("rb_latency", cyc, 2);
        chk("rb_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 0;

        // Starvation: continuous loads with a fetch waiting
        @(negedge clk);
        i_req = 1; i_addr = 32'h20;
        d_req = 1; d_we = 0; d_addr = 32'h104;
        n_d = 0; got_i = 0; prev = 0;
        for (int k = 0; k < 80 && !got_i; k++) begin
            @(negedge clk);
            chk("stv_stall_if", stall_if, 1'b1);
            if (mem_req && !prev) begin
                if (mem_addr >= 32'h100) n_d++;
                else got_i = 1;
            end
            prev = mem_req;
            if (d_ready) begin
                chk("stv_d_rdata", d_rdata, model_mem[d_addr[8:2]]);
                d_addr = d_addr + 4;
            end
        end
        chk("stv_d_grants", n_d, SMAX);
        chk("stv_i_grant", got_i, 1'b1);
        wait_i(10, cyc);
        chk("stv_i_bound", cyc > 0, 1'b1);
        chk("stv_i_rdata", i_rdata, model_mem[8]);
        i_req = 0;
        wait_d(10, cyc);
        chk("stv_d_bound", cyc > 0, 1'b1);
        d_req = 0;

        // Cancel in IDLE holds the fetch off for that cycle
        @(negedge clk);
        i_req = 1; i_addr = 32'h28; i_cancel = 1;
        @(negedge clk);
        chk("cxi_no_grant", mem_req, 1'b0);
        i_cancel = 0;
        @(negedge clk);
        chk("cxi_grant", mem_req, 1'b1);
        wait_i(10, cyc);
        chk("cxi_rdata", i_rdata, model_mem[10]);
        i_req = 0;

        // Cancel during I_BUSY, ack on the third mem_req cycle
        ack_lat = 2;
        @(negedge clk);
        i_req = 1; i_addr = 32'h24;
        @(negedge clk);
        chk("cx_busy", mem_req, 1'b1);
        i_cancel = 1; i_req = 0;
        d_req = 1; d_we = 0; d_addr = 32'h108;
        @(negedge clk);
        i_cancel = 0;
        chk("cx_nr1", i_ready, 1'b0);
        @(negedge clk);
        chk("cx_nr2", i_ready, 1'b0);
        chk("cx_held", mem_req, 1'b1);
        @(negedge clk);
        chk("cx_no_ready", i_ready, 1'b0);
        chk("cx_idle", mem_req, 1'b0);
        @(negedge clk);
        chk("cx_d_grant", mem_req, 1'b1);
        chk("cx_d_addr", mem_addr, 32'h108);
        chk("cx_nr3", i_ready, 1'b0);
        wait_d(10, cyc);
        chk("cx_d_rdata", d_rdata, model_mem[66]);
        d_req = 0;

        // Randomized traffic against the memory reference
        ack_lat = -2;
        prev = 0; d_run = 0; i_wait = 0; d_wait = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            chk("rnd_stall_if", stall_if, i_req & ~i_ready);
            chk("rnd_stall_mem", stall_mem, d_req & ~d_ready);
            if (mem_req && !prev) begin
                if (mem_addr >= 32'h100) begin
                    chk("rnd_d_addr", mem_addr, d_addr);
                    chk("rnd_d_we", mem_we, d_we);
                    chk("rnd_d_wstrb", mem_wstrb, d_we ? d_wstrb : 4'h0);
                    if (d_we) chk("rnd_d_wdata", mem_wdata, d_wdata);
                    if (i_req) d_run++;
                    chk("rnd_starve", d_run <= SMAX, 1'b1);
                end else begin
                    chk("rnd_i_addr", mem_addr, i_addr);
                    chk("rnd_i_rd", {mem_we, mem_wstrb}, 5'h0);
                    d_run = 0;
                end
            end
            prev = mem_req;
            if (i_ready) begin
                chk("rnd_i_rdata", i_rdata, model_mem[i_addr[8:2]]);
                chk("rnd_i_lat", i_wait <= 40, 1'b1);
                i_req = 0;
            end
            if (d_ready) begin
                if (d_we) model_store(d_addr, d_wdata, d_wstrb);
                else chk("rnd_d_rdata", d_rdata, model_mem[d_addr[8:2]]);
                chk("rnd_d_lat", d_wait <= 40, 1'b1);
                d_req = 0;
            end
            if (i_req) i_wait++;
            if (d_req) d_wait++;
            if (c < 560 && !i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_wait = 0;
                i_addr = 32'($urandom_range(0, 63)) << 2;
            end
            if (c < 560 && !d_req && $urandom_range(0, 1) == 0) begin
                d_req = 1; d_wait = 0;
                d_we = 1'($urandom_range(0, 1));
                d_addr = 32'h100 + (32'($urandom_range(0, 31)) << 2);
                d_wdata = $urandom;
                d_wstrb = 4'($urandom_range(0, 15));
            end
        end
        chk("rnd_drain", {i_req, d_req}, 2'b00);
        chk("rnd_no_err", bus_err, 1'b0);

        // Prime d_rdata with a nonzero word, then time out a load
        ack_lat = 0;
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'h10;
        wait_d(10, cyc);
        chk("to_prime", d_rdata, 32'h0010_0093);
        d_req = 0;
        ack_lat = -1;
        @(negedge clk);
        d_req = 1; d_addr = 32'h10C;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            chk("to_req_held", mem_req, 1'b1);
            chk("to_no_err", bus_err, 1'b0);
        end
        @(negedge clk);
        chk("to_req_drop", mem_req, 1'b0);
        chk("to_d_ready", d_ready, 1'b1);
        chk("to_d_rdata", d_rdata, 32'h0);
        chk("to_bus_err", bus_err, 1'b1);
        d_req = 0;
        ack_lat = 0;
        @(negedge clk);
        chk("to_pulse", d_ready, 1'b0);
        i_req = 1; i_addr = 32'h10;
        wait_i(10, cyc);
        chk("to_fetch_ok", i_rdata, 32'h0010_0093);
        chk("to_sticky", bus_err, 1'b1);
        i_req = 0;

        // Reset in D_BUSY abandons the access at once
        ack_lat = -1;
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h120;
        d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
        @(negedge clk); @(negedge clk);
        chk("rb_busy", mem_req, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("rb_async_req", mem_req, 1'b0);
        chk("rb_err_clr", bus_err, 1'b0);
        d_req = 0;
        @(negedge clk);
        reset = 1'b0;
        ack_lat = 0;
        chk("rb_no_ready", d_ready, 1'b0);
        @(negedge clk);
        chk("rb_no_ready2", d_ready, 1'b0);
        chk("rb_idle", mem_req, 1'b0);
        i_req = 1; i_addr = 32'h10;
        wait_i(10, cyc);
        chk("rb_lat", cyc, 2);
        chk("rb_no_write", dev_mem[72], model_mem[72]);
        i_req = 0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
